// File: rtl/ps2_device_port.sv
// Device-side PS/2 transceiver: generates the PS/2 clock, sends queued bytes
// to the host and receives host command bytes with the acknowledge clock.
module ps2_device_port #(
  parameter int CLK_HALF_PERIOD = 2500,
  parameter int FIFO_DEPTH      = 8,
  parameter int INHIBIT_MIN     = 5000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy
);

  localparam int PW = (CLK_HALF_PERIOD > 1) ? $clog2(CLK_HALF_PERIOD) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = $clog2(INHIBIT_MIN + 1);

  localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_HALF_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_SETTLE = PW'(2);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [IW-1:0] INH_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0] INH_ONE    = IW'(1);
  localparam logic [IW-1:0] INH_MAX    = IW'(INHIBIT_MIN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX      = 3'd1,
    ST_RX      = 3'd2,
    ST_ACK     = 3'd3,
    ST_INHIBIT = 3'd4,
    ST_GUARD   = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  function automatic logic rx_frame_ok(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

  logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          tx_ready_r;
  logic          push_s, pop_s;
  logic [7:0]    fifo_head_s;

  state_t        state_r;
  logic [PW-1:0] phase_r;
  logic [3:0]    bit_r;
  logic          low_r;
  logic [IW-1:0] inh_cnt_r;
  logic [7:0]    tx_byte_r;
  logic [10:0]   tx_frame_s;
  logic [9:0]    rx_shift_r;
  logic [1:0]    ack_step_r;
  logic          ack_done_s;
  logic          from_tx_r;
  logic          clk_oe_r, dat_oe_r;
  logic [7:0]    rx_data_r;
  logic          rx_valid_r, rx_error_r, busy_r;

  // Pad level synchronisers; the released bus idles high.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk_in;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_dat_in;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign push_s      = tx_valid && tx_ready_r;
  assign pop_s       = (state_r == ST_GUARD) && (phase_r == PHASE_LAST) && from_tx_r;
  assign fifo_head_s = fifo_mem_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + COUNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - COUNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Transmit FIFO storage, pointers and registered ready flag.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= COUNT_ZERO;
      tx_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= tx_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      tx_ready_r <= (count_nxt_s != COUNT_FULL);
    end
  end

  assign tx_frame_s = {1'b1, odd_parity(tx_byte_r), tx_byte_r, 1'b0};
  // Ack clock ends after its low phase, or right after the 10th clock when stop was 0.
  assign ack_done_s = (phase_r == PHASE_LAST) &&
                      ((ack_step_r == 2'd2) || (ack_step_r == 2'd3) ||
                       ((ack_step_r == 2'd0) && !rx_shift_r[9]));

  // Link sequencer: phase timing, bit counting, pad drive and receive status.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      phase_r    <= PHASE_ZERO;
      bit_r      <= 4'd0;
      low_r      <= 1'b0;
      inh_cnt_r  <= INH_ZERO;
      tx_byte_r  <= 8'h00;
      rx_shift_r <= 10'h000;
      ack_step_r <= 2'd0;
      from_tx_r  <= 1'b0;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          phase_r  <= PHASE_ZERO;
          low_r    <= 1'b0;
          bit_r    <= 4'd0;
          if (!clk_sync_r) begin
            state_r   <= ST_INHIBIT;
            inh_cnt_r <= INH_ZERO;
            busy_r    <= 1'b1;
          end else if ((count_r != COUNT_ZERO) && dat_sync_r) begin
            state_r   <= ST_TX;
            tx_byte_r <= fifo_head_s;
            dat_oe_r  <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        ST_TX: begin
          if (!low_r && (phase_r >= PHASE_SETTLE) && !clk_sync_r) begin
            // Host pulled the clock low while we released it: back off, keep the byte.
            clk_oe_r  <= 1'b0;
            dat_oe_r  <= 1'b0;
            phase_r   <= PHASE_ZERO;
            inh_cnt_r <= INH_ZERO;
            state_r   <= ST_INHIBIT;
          end else if (phase_r != PHASE_LAST) begin
            phase_r <= phase_r + PW'(1);
          end else if (!low_r) begin
            phase_r  <= PHASE_ZERO;
            low_r    <= 1'b1;
            clk_oe_r <= 1'b1;
          end else if (bit_r == 4'd10) begin
            phase_r   <= PHASE_ZERO;
            low_r     <= 1'b0;
            clk_oe_r  <= 1'b0;
            dat_oe_r  <= 1'b0;
            from_tx_r <= 1'b1;
            state_r   <= ST_GUARD;
          end else begin
            phase_r  <= PHASE_ZERO;
            low_r    <= 1'b0;
            clk_oe_r <= 1'b0;
            bit_r    <= bit_r + 4'd1;
            dat_oe_r <= ~tx_frame_s[bit_r + 4'd1];
          end
        end
        ST_INHIBIT: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          if (!clk_sync_r) begin
            if (inh_cnt_r != INH_MAX) begin
              inh_cnt_r <= inh_cnt_r + INH_ONE;
            end
          end else if ((inh_cnt_r == INH_MAX) && !dat_sync_r) begin
            state_r <= ST_RX;
            phase_r <= PHASE_ZERO;
            low_r   <= 1'b0;
            bit_r   <= 4'd0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RX: begin
          if (phase_r != PHASE_LAST) begin
            phase_r <= phase_r + PW'(1);
          end else if (!low_r) begin
            phase_r    <= PHASE_ZERO;
            rx_shift_r <= {dat_sync_r, rx_shift_r[9:1]};
            clk_oe_r   <= 1'b1;
            if (bit_r == 4'd9) begin
              ack_step_r <= 2'd0;
              state_r    <= ST_ACK;
            end else begin
              low_r <= 1'b1;
            end
          end else begin
            phase_r  <= PHASE_ZERO;
            low_r    <= 1'b0;
            clk_oe_r <= 1'b0;
            bit_r    <= bit_r + 4'd1;
          end
        end
        ST_ACK: begin
          if (ack_done_s) begin
            phase_r   <= PHASE_ZERO;
            clk_oe_r  <= 1'b0;
            dat_oe_r  <= 1'b0;
            from_tx_r <= 1'b0;
            state_r   <= ST_GUARD;
            if (rx_frame_ok(rx_shift_r)) begin
              rx_data_r  <= rx_shift_r[7:0];
              rx_valid_r <= 1'b1;
            end else begin
              rx_error_r <= 1'b1;
            end
          end else if (phase_r != PHASE_LAST) begin
            phase_r <= phase_r + PW'(1);
          end else if (ack_step_r == 2'd0) begin
            phase_r    <= PHASE_ZERO;
            ack_step_r <= 2'd1;
            clk_oe_r   <= 1'b0;
            dat_oe_r   <= 1'b1;
          end else begin
            phase_r    <= PHASE_ZERO;
            ack_step_r <= 2'd2;
            clk_oe_r   <= 1'b1;
          end
        end
        ST_GUARD: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          if (phase_r != PHASE_LAST) begin
            phase_r <= phase_r + PW'(1);
          end else begin
            phase_r   <= PHASE_ZERO;
            from_tx_r <= 1'b0;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          phase_r  <= PHASE_ZERO;
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready   = tx_ready_r;
  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_error   = rx_error_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ps2_device_port.sv
// Directed bench for ps2_device_port: a host model on open-drain pads and a
// pad monitor that records the device's line level at every clock low pulse.
module tb_ps2_device_port;

  localparam int HP   = 4;
  localparam int IMIN = 16;
  localparam int HIST = 1024;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy;
  logic       host_clk = 1'b1;
  logic       host_dat = 1'b1;

  assign ps2_clk_in = host_clk & ~ps2_clk_oe;
  assign ps2_dat_in = host_dat & ~ps2_dat_oe;

  ps2_device_port #(.CLK_HALF_PERIOD(HP), .FIFO_DEPTH(8), .INHIBIT_MIN(IMIN)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad monitor, sampled 1 time unit after each rising edge.
  logic hist [HIST];
  int   bit_total = 0;
  int   n_falls   = 0;
  int   low_len   = 0;
  int   bad_len   = 0;
  int   n_valid   = 0;
  int   n_err     = 0;
  logic clk_oe_q  = 1'b0;

  always @(posedge CLOCK_50) begin
    #1;
    if (ps2_clk_oe && !clk_oe_q) begin
      hist[bit_total % HIST] = !ps2_dat_oe;
      bit_total++;
      low_len = 1;
    end else if (ps2_clk_oe) begin
      low_len++;
    end
    if (!ps2_clk_oe && clk_oe_q) begin
      n_falls++;
      if (low_len != HP) bad_len++;
    end
    if (rx_valid) n_valid++;
    if (rx_error) n_err++;
    clk_oe_q = ps2_clk_oe;
  end

  task automatic push(input logic [7:0] b);
    @(negedge CLOCK_50);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  task automatic wait_bits(input string tag, input int target);
    int budget = 3000;
    while (bit_total < target && budget > 0) begin
      @(negedge CLOCK_50);
      budget--;
    end
    check({tag, "_in_time"}, 32'(bit_total >= target), 32'd1);
  endtask

  task automatic wait_falls(input int target);
    int budget = 3000;
    while (n_falls < target && budget > 0) begin
      @(negedge CLOCK_50);
      budget--;
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget = 3000;
    @(negedge CLOCK_50);
    while (busy && budget > 0) begin
      @(negedge CLOCK_50);
      budget--;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Collects the next 11 device clock pulses and compares them with a full frame.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    int          start;
    logic [10:0] got;
    logic [10:0] exp;
    start = bit_total;
    exp   = {1'b1, ~^b, b, 1'b0};
    wait_bits(tag, start + 11);
    for (int i = 0; i < 11; i++) got[i] = hist[(start + i) % HIST];
    check(tag, 32'(got), 32'(exp));
  endtask

  // Host request-to-send followed by 8 data bits, parity and stop=1.
  task automatic host_cmd(input logic [7:0] b, input logic par);
    logic [9:0] f;
    int         f0;
    f = {1'b1, par, b};
    host_clk = 1'b0;
    repeat (18) @(negedge CLOCK_50);
    host_dat = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    f0 = n_falls;
    host_clk = 1'b1;
    @(negedge CLOCK_50);
    host_dat = f[0];
    for (int k = 1; k < 10; k++) begin
      wait_falls(f0 + k);
      host_dat = f[k];
    end
    wait_falls(f0 + 10);
    host_dat = 1'b1;
  endtask

  task automatic rx_scenario(input string tag, input logic [7:0] b, input logic par,
                             input logic exp_ok, input logic [7:0] exp_data);
    int         b0, v0, e0;
    logic [9:0] rel;
    b0 = bit_total;
    v0 = n_valid;
    e0 = n_err;
    host_cmd(b, par);
    wait_idle(tag);
    check({tag, "_clocks"}, 32'(bit_total - b0), 32'd11);
    for (int i = 0; i < 10; i++) rel[i] = hist[(b0 + i) % HIST];
    check({tag, "_dat_released"}, 32'(rel), 32'h3FF);
    check({tag, "_ack"}, 32'(hist[(b0 + 10) % HIST]), 32'd0);
    check({tag, "_rx_valid_pulses"}, 32'(n_valid - v0), 32'(exp_ok));
    check({tag, "_rx_error_pulses"}, 32'(n_err - e0), 32'(!exp_ok));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_data));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0, b_rst;

    // Reset state.
    repeat (3) @(negedge CLOCK_50);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_error", 32'(rx_error), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // 1: single byte 0x1C.
    b0 = bit_total;
    push(8'h1C);
    expect_frame("s1_frame", 8'h1C);
    wait_idle("s1");
    check("s1_pulse_len_errors", 32'(bad_len), 32'd0);
    check("s1_tx_ready", 32'(tx_ready), 32'd1);
    repeat (30) @(negedge CLOCK_50);
    check("s1_pulses", 32'(bit_total - b0), 32'd11);
    check("s1_busy_after", 32'(busy), 32'd0);

    // 2: host command 0xED with good parity.
    rx_scenario("s2", 8'hED, 1'b1, 1'b1, 8'hED);

    // 3: host command with bad parity; rx_data keeps 0xED.
    rx_scenario("s3", 8'hF4, 1'b1, 1'b0, 8'hED);

    // 4: host aborts during bit 5's high phase.
    f0 = n_falls;
    push(8'h1C);
    wait_falls(f0 + 5);
    host_clk = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("s4_clk_released", 32'(ps2_clk_oe), 32'd0);
    check("s4_dat_released", 32'(ps2_dat_oe), 32'd0);
    check("s4_busy_inhibit", 32'(busy), 32'd1);
    repeat (3) @(negedge CLOCK_50);
    host_clk = 1'b1;
    b0 = bit_total;
    expect_frame("s4_resend", 8'h1C);
    wait_idle("s4");
    repeat (30) @(negedge CLOCK_50);
    check("s4_single_resend", 32'(bit_total - b0), 32'd11);
    check("s4_tx_ready", 32'(tx_ready), 32'd1);

    // 5: fill the FIFO under inhibit, overflow push dropped.
    host_clk = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("s5_ready_before_push_%0d", i), 32'(tx_ready), 32'(i < 8));
      tx_valid = 1'b1;
      tx_data  = i[7:0];
      @(negedge CLOCK_50);
    end
    tx_valid = 1'b0;
    check("s5_full", 32'(tx_ready), 32'd0);
    host_clk = 1'b1;
    b0 = bit_total;
    for (int i = 0; i < 8; i++) expect_frame($sformatf("s5_frame_%0d", i), i[7:0]);
    wait_idle("s5");
    repeat (40) @(negedge CLOCK_50);
    check("s5_total_pulses", 32'(bit_total - b0), 32'd88);
    check("s5_tx_ready", 32'(tx_ready), 32'd1);

    // 6: asynchronous reset during bit 3's low phase.
    b0 = bit_total;
    push(8'h1C);
    wait_bits("s6_bit3", b0 + 4);
    check("s6_clk_low_before_reset", 32'(ps2_clk_oe), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_clk_oe_async", 32'(ps2_clk_oe), 32'd0);
    check("s6_dat_oe_async", 32'(ps2_dat_oe), 32'd0);
    check("s6_tx_ready", 32'(tx_ready), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    b_rst = bit_total;
    repeat (40) @(negedge CLOCK_50);
    check("s6_fifo_empty_no_frame", 32'(bit_total - b_rst), 32'd0);
    check("s6_idle_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
